// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies and small op-class helpers.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int          MDU_LAT_MUL        = 5;
  localparam int          MDU_LAT_DIV        = 10;
  localparam logic [31:0] MDU_RESULT_DEFAULT = 32'h0;

  function automatic logic is_mul(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_core.sv
// Combinational 64-bit multiply/divide datapath. wr_en is low for a divide
// by zero so HI/LO keep their previous contents.
module mdu_core
  import mdu_ctrl_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] res,
  output logic        wr_en
);

  logic               div0;
  logic               div_ovf;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] dvd_s;
  logic signed [31:0] dvs_s;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] dvs_u;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  always_comb begin
    div0    = (rt == 32'h0);
    div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

    prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u = {32'h0, rs} * {32'h0, rt};

    // Divisor forced to 1 for /0 and INT_MIN/-1 so the divider never overflows;
    // the overflow case is patched to its defined result below.
    dvd_s = $signed(rs);
    dvs_s = (div0 || div_ovf) ? 32'sd1 : $signed(rt);
    quo_s = dvd_s / dvs_s;
    rem_s = dvd_s % dvs_s;
    dvs_u = div0 ? 32'd1 : rt;
    quo_u = rs / dvs_u;
    rem_u = rs % dvs_u;

    res = 64'h0;
    case (op)
      MDU_MULT:  res = $unsigned(prod_s);
      MDU_MULTU: res = prod_u;
      MDU_DIV:   res = div_ovf ? {32'h0, 32'h8000_0000} : {$unsigned(rem_s), $unsigned(quo_s)};
      MDU_DIVU:  res = {rem_u, quo_u};
      default:   res = 64'h0;
    endcase

    wr_en = is_mul(op) || (is_div(op) && !div0);
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage MDU sequencer: issues mult/div ops, counts out their latency,
// owns HI/LO and stalls younger MDU instructions while an op is in flight.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int LAT_MUL = MDU_LAT_MUL,
  parameter int LAT_DIV = MDU_LAT_DIV,
  parameter int CNT_W   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic        i_Req,
  output logic        o_busy,
  output logic        o_stall,
  output logic [31:0] o_result,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, lo_q;
  logic [31:0]       pend_hi_q, pend_lo_q;
  logic              pend_we_q;
  mdu_op_e           op;
  logic              acc;
  logic              launch;
  logic              commit;
  logic [63:0]       core_res;
  logic              core_we;

  assign op      = mdu_op_e'(i_op);
  assign o_busy  = (state_q == ST_BUSY);
  assign o_stall = i_start & o_busy;
  assign acc     = i_start & ~o_busy & ~i_Req;
  assign launch  = acc & (is_mul(op) | is_div(op));
  assign commit  = o_busy & (cnt_q == '0);
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;

  mdu_core u_core (
    .op    (op),
    .rs    (i_rs),
    .rt    (i_rt),
    .res   (core_res),
    .wr_en (core_we)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_BUSY;
          cnt_d   = is_div(op) ? CNT_W'(LAT_DIV - 1) : CNT_W'(LAT_MUL - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result is computed at issue and parked until the latency expires.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (launch) begin
        pend_hi_q <= core_res[63:32];
        pend_lo_q <= core_res[31:0];
        pend_we_q <= core_we;
      end
      if (commit) begin
        if (pend_we_q) begin
          hi_q <= pend_hi_q;
          lo_q <= pend_lo_q;
        end
      end else if (acc && op == MDU_MTHI) begin
        hi_q <= i_rs;
      end else if (acc && op == MDU_MTLO) begin
        lo_q <= i_rs;
      end
    end
  end

  always_comb begin
    case (op)
      MDU_MFHI: o_result = hi_q;
      MDU_MFLO: o_result = lo_q;
      default:  o_result = MDU_RESULT_DEFAULT;
    endcase
  end

endmodule
